// File: rtl/mandel_pkg.sv
// Shared types and fixed-point constants for the Mandelbrot iteration sequencer.
package mandel_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MXX  = 3'd1,
        MYY  = 3'd2,
        MXY  = 3'd3,
        CHK  = 3'd4
    } state_t;

    localparam int DEF_SCALE = 25;
    localparam int DEF_WIDTH = 32;

    // Escape threshold |z|^2 = 4.0 expressed with 'scale' fractional bits.
    function automatic logic [63:0] escape_r2(input int scale);
        return 64'd4 << scale;
    endfunction

    localparam logic signed [DEF_WIDTH:0] ONE = (DEF_WIDTH+1)'(64'd1 << DEF_SCALE);

endpackage

// File: rtl/fixp_mult.sv
// Combinational signed fixed-point multiplier: full product shifted right by SCALE, wrapped to WIDTH+1 bits.
module fixp_mult #(
    parameter int SCALE = 25,
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH:0] a_i,
    input  logic signed [WIDTH:0] b_i,
    output logic signed [WIDTH:0] p_o
);

    logic signed [2*WIDTH+1:0] prod;

    assign prod = a_i * b_i;
    assign p_o  = (WIDTH+1)'(prod >>> SCALE);

endmodule

// File: rtl/mandel_iter_ctrl.sv
// Per-pixel Mandelbrot iteration sequencer; one shared multiplier, four cycles per iteration.
module mandel_iter_ctrl
    import mandel_pkg::*;
#(
    parameter int SCALE  = 25,
    parameter int WIDTH  = 32,
    parameter int ITER_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic signed [WIDTH:0] cr,
    input  logic signed [WIDTH:0] ci,
    input  logic [ITER_W-1:0]   max_iter,
    output logic                busy,
    output logic                done,
    output logic [ITER_W-1:0]   iter,
    output logic                escaped,
    output logic signed [WIDTH:0] z_re,
    output logic signed [WIDTH:0] z_im
);

    localparam int W1 = WIDTH + 1;
    localparam int W2 = WIDTH + 2;
    localparam logic signed [W2-1:0] ESC_R2 = W2'(escape_r2(SCALE));

    state_t                state_q;
    logic signed [W1-1:0]  cr_q, ci_q, x_q, y_q, xx_q, yy_q, xy_q;
    logic signed [W1-1:0]  zre_q, zim_q;
    logic [ITER_W-1:0]     m_q, cnt_q, iter_q;
    logic                  busy_q, done_q, esc_q;

    logic signed [W1-1:0]  mul_a, mul_b, mul_p;
    logic signed [W1-1:0]  x_d, y_d;
    logic signed [W2-1:0]  r2;
    logic [ITER_W-1:0]     cnt_d;

    always_comb begin
        mul_a = x_q;
        mul_b = x_q;
        case (state_q)
            MYY: begin mul_a = y_q; mul_b = y_q; end
            MXY: begin mul_a = x_q; mul_b = y_q; end
            default: ;
        endcase
    end

    fixp_mult #(.SCALE(SCALE), .WIDTH(WIDTH)) u_mult (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (mul_p)
    );

    assign r2    = {xx_q[W1-1], xx_q} + {yy_q[W1-1], yy_q};
    assign x_d   = xx_q - yy_q + cr_q;
    assign y_d   = (xy_q <<< 1) + ci_q;
    assign cnt_d = cnt_q + ITER_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cr_q    <= '0;
            ci_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            xx_q    <= '0;
            yy_q    <= '0;
            xy_q    <= '0;
            zre_q   <= '0;
            zim_q   <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            esc_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // busy in IDLE only means an M=0 request waiting one cycle to complete
                    if (busy_q) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else if (start) begin
                        cr_q   <= cr;
                        ci_q   <= ci;
                        m_q    <= max_iter;
                        x_q    <= '0;
                        y_q    <= '0;
                        cnt_q  <= '0;
                        iter_q <= '0;
                        esc_q  <= 1'b0;
                        zre_q  <= '0;
                        zim_q  <= '0;
                        busy_q <= 1'b1;
                        if (max_iter != '0) state_q <= MXX;
                    end
                end
                MXX: begin
                    xx_q    <= mul_p;
                    state_q <= MYY;
                end
                MYY: begin
                    yy_q    <= mul_p;
                    state_q <= MXY;
                end
                MXY: begin
                    xy_q    <= mul_p;
                    state_q <= CHK;
                end
                CHK: begin
                    if (r2 > ESC_R2) begin
                        esc_q   <= 1'b1;
                        iter_q  <= cnt_q;
                        zre_q   <= x_q;
                        zim_q   <= y_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        x_q   <= x_d;
                        y_q   <= y_d;
                        cnt_q <= cnt_d;
                        if (cnt_d == m_q) begin
                            iter_q  <= m_q;
                            zre_q   <= x_d;
                            zim_q   <= y_d;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= MXX;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign iter    = iter_q;
    assign escaped = esc_q;
    assign z_re    = zre_q;
    assign z_im    = zim_q;

endmodule

// File: tb/tb_mandel_iter_ctrl.sv
// Directed table-driven bench for mandel_iter_ctrl with hand sequences for control corner cases.
module tb_mandel_iter_ctrl;
    import mandel_pkg::*;

    localparam int W1 = 33;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic signed [W1-1:0] cr = '0, ci = '0;
    logic [15:0]          max_iter = '0;
    logic                 busy, done, escaped;
    logic [15:0]          iter;
    logic signed [W1-1:0] z_re, z_im;

    int errors = 0;
    int checks = 0;

    mandel_iter_ctrl #(.SCALE(25), .WIDTH(32), .ITER_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cr(cr), .ci(ci),
        .max_iter(max_iter), .busy(busy), .done(done), .iter(iter),
        .escaped(escaped), .z_re(z_re), .z_im(z_im)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [W1-1:0] cr;
        logic signed [W1-1:0] ci;
        logic [15:0]          m;
        int                   edge_n;
        logic [15:0]          iter;
        logic                 esc;
        logic signed [W1-1:0] zre;
        logic signed [W1-1:0] zim;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives start so the next rising edge is edge 0; returns just after that edge.
    task automatic start_run(input logic signed [W1-1:0] r, input logic signed [W1-1:0] i,
                             input logic [15:0] m, input bit hold);
        @(negedge clk);
        cr = r; ci = i; max_iter = m; start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(output int edges);
        edges = -1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                edges = k;
                break;
            end
        end
        if (edges < 0) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: got no done expected done within 300 edges");
        end
    endtask

    initial begin
        int e;
        vecs[0] = '{cr: '0,        ci: '0,  m: 16, edge_n: 64, iter: 16, esc: 0, zre: '0,       zim: '0};
        vecs[1] = '{cr: 3*ONE,     ci: '0,  m: 16, edge_n: 8,  iter: 1,  esc: 1, zre: 3*ONE,    zim: '0};
        vecs[2] = '{cr: ONE,       ci: ONE, m: 16, edge_n: 12, iter: 2,  esc: 1, zre: ONE,      zim: 3*ONE};
        vecs[3] = '{cr: 2*ONE,     ci: '0,  m: 8,  edge_n: 12, iter: 2,  esc: 1, zre: 6*ONE,    zim: '0};
        vecs[4] = '{cr: -2*ONE,    ci: '0,  m: 5,  edge_n: 20, iter: 5,  esc: 0, zre: 2*ONE,    zim: '0};
        vecs[5] = '{cr: -2*ONE,    ci: '0,  m: 0,  edge_n: 1,  iter: 0,  esc: 0, zre: '0,       zim: '0};

        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_iter", 64'(iter), 64'd0);
        chk("rst_z", 64'({z_re, z_im}), 64'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            start_run(vecs[v].cr, vecs[v].ci, vecs[v].m, 1'b0);
            chk($sformatf("v%0d_busy_start", v), 64'(busy), 64'd1);
            wait_done(e);
            chk($sformatf("v%0d_latency", v), 64'(e), 64'(vecs[v].edge_n));
            chk($sformatf("v%0d_busy_done", v), 64'(busy), 64'd0);
            chk($sformatf("v%0d_iter", v), 64'(iter), 64'(vecs[v].iter));
            chk($sformatf("v%0d_esc", v), 64'(escaped), 64'(vecs[v].esc));
            chk($sformatf("v%0d_zre", v), 64'(z_re), 64'(vecs[v].zre));
            chk($sformatf("v%0d_zim", v), 64'(z_im), 64'(vecs[v].zim));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", v), 64'(done), 64'd0);
            chk($sformatf("v%0d_iter_held", v), 64'(iter), 64'(vecs[v].iter));
        end

        // xx of the second pass for c=3.0 is registered at edge 5
        start_run(3*ONE, '0, 16, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("xx_second_pass", 64'(dut.xx_q), 64'(9*ONE));
        wait_done(e);
        chk("xx_run_latency", 64'(e + 5), 64'd8);

        // start while busy is ignored
        start_run(ONE, ONE, 16, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        cr = 3*ONE; ci = '0; max_iter = 1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(e);
        chk("busy_ign_latency", 64'(e + 3), 64'd12);
        chk("busy_ign_iter", 64'(iter), 64'd2);
        chk("busy_ign_esc", 64'(escaped), 64'd1);
        chk("busy_ign_zim", 64'(z_im), 64'(3*ONE));

        // reset mid-run around edge 6
        start_run('0, '0, 16, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_iter", 64'(iter), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_run(ONE, ONE, 16, 1'b0);
        wait_done(e);
        chk("postrst_latency", 64'(e), 64'd12);
        chk("postrst_iter", 64'(iter), 64'd2);

        // start held through done: back-to-back runs
        start_run(ONE, ONE, 16, 1'b1);
        wait_done(e);
        chk("b2b_first_latency", 64'(e), 64'd12);
        chk("b2b_first_iter", 64'(iter), 64'd2);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_second_busy", 64'(busy), 64'd1);
        chk("b2b_cleared_iter", 64'(iter), 64'd0);
        chk("b2b_cleared_esc", 64'(escaped), 64'd0);
        wait_done(e);
        chk("b2b_second_latency", 64'(e), 64'd12);
        chk("b2b_second_iter", 64'(iter), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
